// File: rtl/reaction_seq_ctrl.sv
// rtl/reaction_seq_ctrl.sv - reaction-timer game sequencer: delay, arm, result, false start, timeout, best time
module reaction_seq_ctrl #(
  parameter int         MIN_DELAY_MS = 1000,
  parameter bit         RAND_EN      = 1'b1,
  parameter logic [9:0] LFSR_SEED    = 10'h2A5,
  parameter int         DELAY_W      = 11
) (
  input  logic        clk,
  input  logic        ar,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic        clr,
  input  logic [3:0]  cnt_ones,
  input  logic [3:0]  cnt_tens,
  input  logic [3:0]  cnt_hunds,
  output logic        led_out,
  output logic        counter_en,
  output logic        counter_clr,
  output logic        false_start,
  output logic        timeout,
  output logic        best_valid,
  output logic [11:0] best_bcd,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DELAY  = 3'd1;
  localparam logic [2:0] S_ARMED  = 3'd2;
  localparam logic [2:0] S_RESULT = 3'd3;
  localparam logic [2:0] S_EARLY  = 3'd4;
  localparam logic [2:0] S_TMO    = 3'd5;

  logic               start_q, stop_q, clr_q;
  logic               start_e, stop_e, clr_e;
  logic [9:0]         lfsr;
  logic [DELAY_W-1:0] delay_cnt;
  logic [DELAY_W-1:0] delay_load;
  logic [2:0]         next_state;
  logic               load_delay;
  logic               dec_delay;
  logic               clr_best;
  logic               result_first;
  logic [11:0]        cnt_val;
  logic               cnt_full;

  assign start_e    = start & ~start_q;
  assign stop_e     = stop & ~stop_q;
  assign clr_e      = clr & ~clr_q;
  assign cnt_val    = {cnt_hunds, cnt_tens, cnt_ones};
  assign cnt_full   = (cnt_val == 12'h999);
  assign delay_load = DELAY_W'(MIN_DELAY_MS) + (RAND_EN ? DELAY_W'(lfsr) : '0);

  // previous button levels for rising-edge detection
  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
      clr_q   <= clr;
    end
  end

  // free-running x^10+x^7+1 LFSR; a nonzero seed keeps it out of the all-zero lockup
  always_ff @(posedge clk or posedge ar) begin
    if (ar) lfsr <= LFSR_SEED;
    else    lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
  end

  // state register, registered LED and first-RESULT-cycle marker
  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      state        <= S_IDLE;
      led_out      <= 1'b0;
      result_first <= 1'b0;
    end else begin
      state        <= next_state;
      led_out      <= (next_state == S_ARMED);
      result_first <= (next_state == S_RESULT) && (state != S_RESULT);
    end
  end

  // next-state decode; clr beats stop beats tick beats start
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (!clr_e && start_e) next_state = S_DELAY;
      S_DELAY: begin
        if (clr_e)                          next_state = S_IDLE;
        else if (stop_e)                    next_state = S_EARLY;
        else if (tick && delay_cnt <= 1)    next_state = S_ARMED;
      end
      S_ARMED: begin
        if (clr_e)                          next_state = S_IDLE;
        else if (stop_e)                    next_state = S_RESULT;
        else if (tick && cnt_full)          next_state = S_TMO;
      end
      S_RESULT, S_EARLY, S_TMO: begin
        if (clr_e)                          next_state = S_IDLE;
        else if (start_e)                   next_state = S_DELAY;
      end
      default:                              next_state = S_IDLE;
    endcase
  end

  // outputs and datapath strobes derived from state and this cycle's edges
  always_comb begin
    load_delay  = (next_state == S_DELAY) && (state != S_DELAY);
    dec_delay   = (state == S_DELAY) && tick && !clr_e && !stop_e;
    clr_best    = (state == S_IDLE) && clr_e;
    counter_clr = !ar && (load_delay || (clr_e && state != S_IDLE));
    counter_en  = !ar && (state == S_ARMED) && tick && !stop_e && !cnt_full;
    false_start = (state == S_EARLY);
    timeout     = (state == S_TMO);
  end

  // pre-LED delay down-counter; a zero load expires on the first tick like a load of 1
  always_ff @(posedge clk or posedge ar) begin
    if (ar)              delay_cnt <= '0;
    else if (load_delay) delay_cnt <= delay_load;
    else if (dec_delay)  delay_cnt <= delay_cnt - 1'b1;
  end

  // best-time register; BCD digits compare correctly as a plain 12-bit unsigned value
  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      best_bcd   <= 12'h999;
      best_valid <= 1'b0;
    end else if (clr_best) begin
      best_bcd   <= 12'h999;
      best_valid <= 1'b0;
    end else if (result_first && (!best_valid || cnt_val < best_bcd)) begin
      best_bcd   <= cnt_val;
      best_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reaction_seq_ctrl.sv
// tb/tb_reaction_seq_ctrl.sv - directed self-checking bench for reaction_seq_ctrl
module tb_reaction_seq_ctrl;

  logic clk = 1'b0;
  logic ar = 1'b1;
  logic tick = 1'b0, start = 1'b0, stop = 1'b0, clr = 1'b0;

  logic        led0, en0, cclr0, fs0, tmo0, bv0;
  logic [11:0] best0;
  logic [2:0]  st0;
  logic        led1, en1, cclr1, fs1, tmo1, bv1;
  logic [11:0] best1;
  logic [2:0]  st1;

  int          cnt_bin = 0;
  int          en_count = 0;
  logic        load_req = 1'b0;
  int          load_val = 0;
  logic [11:0] cnt0;
  logic [9:0]  lfsr_m;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  assign cnt0 = to_bcd(cnt_bin);

  reaction_seq_ctrl #(.MIN_DELAY_MS(4), .RAND_EN(1'b0), .LFSR_SEED(10'h2A5), .DELAY_W(11)) dut0 (
    .clk(clk), .ar(ar), .tick(tick), .start(start), .stop(stop), .clr(clr),
    .cnt_ones(cnt0[3:0]), .cnt_tens(cnt0[7:4]), .cnt_hunds(cnt0[11:8]),
    .led_out(led0), .counter_en(en0), .counter_clr(cclr0), .false_start(fs0),
    .timeout(tmo0), .best_valid(bv0), .best_bcd(best0), .state(st0));

  reaction_seq_ctrl #(.MIN_DELAY_MS(4), .RAND_EN(1'b1), .LFSR_SEED(10'h2A5), .DELAY_W(11)) dut1 (
    .clk(clk), .ar(ar), .tick(tick), .start(start), .stop(stop), .clr(clr),
    .cnt_ones(4'h0), .cnt_tens(4'h0), .cnt_hunds(4'h0),
    .led_out(led1), .counter_en(en1), .counter_clr(cclr1), .false_start(fs1),
    .timeout(tmo1), .best_valid(bv1), .best_bcd(best1), .state(st1));

  // binary model of the external BCD counter chain
  always @(posedge clk) begin
    if (load_req)                      cnt_bin <= load_val;
    else if (cclr0)                    cnt_bin <= 0;
    else if (en0 && cnt_bin < 999)     cnt_bin <= cnt_bin + 1;
    if (en0) en_count <= en_count + 1;
  end

  // reference LFSR, x^10+x^7+1
  always @(posedge clk or posedge ar) begin
    if (ar) lfsr_m <= 10'h2A5;
    else    lfsr_m <= {lfsr_m[8:0], lfsr_m[9] ^ lfsr_m[6]};
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic press(input int which, output logic clr_seen);
    @(negedge clk);
    case (which)
      0: start = 1'b1;
      1: stop = 1'b1;
      default: clr = 1'b1;
    endcase
    #1 clr_seen = cclr0;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
  endtask

  task automatic run_round(input int n);
    logic c;
    press(0, c);
    do_ticks(4);
    do_ticks(n);
    press(1, c);
  endtask

  task automatic rand_delay(input string tag, input int wait_cycles);
    int exp_len;
    int k;
    bit found;
    @(negedge clk);
    ar = 1'b1;
    @(negedge clk);
    ar = 1'b0;
    for (int i = 0; i < wait_cycles; i++) @(negedge clk);
    start = 1'b1;
    exp_len = 4 + int'(lfsr_m);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_in_delay"}, st1, 3'd1);
    found = 1'b0;
    k = 0;
    for (int i = 1; i <= 1100 && !found; i++) begin
      do_ticks(1);
      if (st1 == 3'd2) begin
        found = 1'b1;
        k = i;
      end
    end
    check(tag, k, exp_len);
  endtask

  initial begin
    logic c;
    int en_before;

    // reset values
    #12;
    check("rst_state", st0, 3'd0);
    check("rst_led", led0, 1'b0);
    check("rst_en", en0, 1'b0);
    check("rst_clr", cclr0, 1'b0);
    check("rst_fs", fs0, 1'b0);
    check("rst_tmo", tmo0, 1'b0);
    check("rst_bv", bv0, 1'b0);
    check("rst_best", best0, 12'h999);
    @(negedge clk);
    ar = 1'b0;

    // round 1: 4-tick delay then 37 counts
    press(0, c);
    check("r1_start_clr", c, 1'b1);
    check("r1_delay", st0, 3'd1);
    do_ticks(3);
    check("r1_not_armed_yet", st0, 3'd1);
    check("r1_led_off", led0, 1'b0);
    do_ticks(1);
    check("r1_armed", st0, 3'd2);
    check("r1_led_on", led0, 1'b1);
    do_ticks(37);
    press(1, c);
    check("r1_result", st0, 3'd3);
    check("r1_led_off2", led0, 1'b0);
    check("r1_cnt", cnt0, 12'h037);
    check("r1_best", best0, 12'h037);
    check("r1_bv", bv0, 1'b1);

    // later rounds: slower, faster, tie
    run_round(52);
    check("r2_cnt", cnt0, 12'h052);
    check("r2_best", best0, 12'h037);
    run_round(21);
    check("r3_best", best0, 12'h021);
    run_round(21);
    check("r4_tie_best", best0, 12'h021);
    check("r4_bv", bv0, 1'b1);

    // false start
    en_before = en_count;
    press(0, c);
    check("fs_start_clr", c, 1'b1);
    do_ticks(2);
    press(1, c);
    check("fs_state", st0, 3'd4);
    check("fs_flag", fs0, 1'b1);
    check("fs_no_en", en_count, en_before);
    check("fs_best", best0, 12'h021);
    press(0, c);
    check("fs_restart_clr", c, 1'b1);
    check("fs_restart", st0, 3'd1);
    check("fs_flag_off", fs0, 1'b0);

    // timeout at 999
    do_ticks(4);
    check("to_armed", st0, 3'd2);
    @(negedge clk); load_req = 1'b1; load_val = 998;
    @(negedge clk); load_req = 1'b0;
    do_ticks(1);
    check("to_cnt999", cnt0, 12'h999);
    check("to_still_armed", st0, 3'd2);
    @(negedge clk); tick = 1'b1;
    #1 check("to_en_blocked", en0, 1'b0);
    @(negedge clk); tick = 1'b0;
    check("to_state", st0, 3'd5);
    check("to_flag", tmo0, 1'b1);
    check("to_cnt_hold", cnt0, 12'h999);
    check("to_best", best0, 12'h021);

    // clr and stop together in ARMED: clr wins
    press(0, c);
    do_ticks(4);
    check("cs_armed", st0, 3'd2);
    @(negedge clk); clr = 1'b1; stop = 1'b1;
    #1 check("cs_clr_pulse", cclr0, 1'b1);
    @(negedge clk); clr = 1'b0; stop = 1'b0;
    check("cs_idle", st0, 3'd0);
    check("cs_led", led0, 1'b0);
    press(2, c);
    check("idle_clr_bv", bv0, 1'b0);
    check("idle_clr_best", best0, 12'h999);

    // asynchronous reset mid-ARMED
    run_round(10);
    check("ar_pre_bv", bv0, 1'b1);
    press(0, c);
    do_ticks(4);
    check("ar_pre_led", led0, 1'b1);
    @(negedge clk);
    #2 ar = 1'b1;
    #1;
    check("ar_led_async", led0, 1'b0);
    check("ar_state_async", st0, 3'd0);
    check("ar_bv", bv0, 1'b0);
    check("ar_best", best0, 12'h999);

    // random delay length against the reference LFSR
    rand_delay("rand_n0", 0);
    rand_delay("rand_n7", 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
